pulse_rate_meter: RTL
=====================

// Module: pulse_rate_meter
// PURPOSE
//  Gated-window pulse counter. Measures the rate of a pulse train (e.g. a divider carry output)
//  by counting PIN rising edges over a fixed window of GATE_CYCLES CLK cycles.
//  Latches the count on DOUT and flags it with a 1-cycle VALID.
//  Sits on the receive side of the team's programmable counters/dividers, closing the loop in self-test.
// PARAMETERS
//  CNT_W        16     width of edge counter and DOUT
//  GATE_W       24     width of gate-window counter
//  GATE_CYCLES  1000   window length in CLK cycles; legal 1 .. 2**GATE_W-1
// PORTS
//  CLK    in   1       system clock, rising edge
//  RST    in   1       reset, asynchronous, active-low
//  EN     in   1       measurement enable; high = run windows back to back
//  PIN    in   1       pulse input, asynchronous to CLK
//  DOUT   out  CNT_W   edge count of last completed window
//  VALID  out  1       1-cycle strobe: DOUT/OVF just updated
//  OVF    out  1       last completed window saturated the edge counter
//  BUSY   out  1       high while a window is open (state GATE)
// BEHAVIOUR
//  Reset (RST=0, async): state=IDLE, sync flops=0, counters=0, DOUT=0, VALID=0, OVF=0, BUSY=0.
//  Input path: PIN -> 2-FF synchroniser -> 3rd flop. edge = s2 & ~s3.
//    A PIN rise is seen as edge 3 CLK edges later.
//    Min detectable PIN high/low time is 1 CLK period; faster input is undefined.
//  FSM, all registered:
//    IDLE : BUSY=0. EN=1 -> GATE; edge_cnt=0, gate_cnt=0, ovf_i=0.
//    GATE : BUSY=1.
//           Each cycle gate_cnt++; if edge, edge_cnt++ with saturation at 2**CNT_W-1 and ovf_i=1.
//           Edges on every GATE cycle, incl. the last, are counted.
//           gate_cnt==GATE_CYCLES-1 -> LATCH.
//           EN=0 -> IDLE immediately (abort); DOUT/OVF keep old values; no VALID.
//    LATCH: DOUT<=edge_cnt (final value incl. last-cycle edge); OVF<=ovf_i; VALID=1 for this 1 cycle.
//           Edges in LATCH are not counted.
//           Then EN=1 -> GATE with counters cleared; EN=0 -> IDLE.
//  Window length: exactly GATE_CYCLES cycles in GATE. Back-to-back period = GATE_CYCLES+1 cycles.
//  DOUT changes only in LATCH and on reset; it is stable between VALID strobes.
//  Saturation: edge_cnt never wraps; OVF=1 iff at least one edge arrived at full count.
//  Reset mid-window: all state cleared at once; no VALID; first window after release starts clean.
//  EN rising while in LATCH: no effect beyond the LATCH->GATE rule.
//  Simultaneous edge and saturation: count holds at max; OVF set.
// TESTING
//  1 GATE_CYCLES=1000, PIN period 10 CLK (50% duty), EN=1 held
//    -> every VALID shows DOUT=100, OVF=0; VALID spacing 1001 cycles.
//  2 GATE_CYCLES=1000, PIN period 8 CLK, any phase
//    -> DOUT=125 each window; BUSY low exactly 1 cycle between windows.
//  3 PIN held 0, GATE_CYCLES=1000 -> DOUT=0, OVF=0, VALID every 1001 cycles.
//  4 GATE_CYCLES=200000, PIN toggles every CLK (period 2) -> DOUT=16'hFFFF, OVF=1.
//    Then PIN period 10 -> next window DOUT=20000, OVF=0.
//  5 EN dropped at cycle 500 of a window
//    -> no VALID, DOUT keeps previous value, BUSY=0 next cycle.
//    EN re-raised -> fresh full window, correct count.
//  6 RST pulsed low mid-window -> outputs 0 immediately.
//    After release with EN=1 -> first VALID after GATE_CYCLES+1 cycles with correct count.

Source files
------------

// File: rtl/pulse_rate_meter.sv
// pulse_rate_meter: counts synchronised PIN rising edges over a GATE_CYCLES window and latches the count
module pulse_rate_meter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 24,
  parameter int GATE_CYCLES = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             PIN,
  output logic [CNT_W-1:0] DOUT,
  output logic             VALID,
  output logic             OVF,
  output logic             BUSY
);
  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;
  state_t state;
  logic s1, s2, s3, rise, sat, ovf_i, ovf_nxt;
  logic [CNT_W-1:0] edge_cnt, edge_nxt;
  logic [GATE_W-1:0] gate_cnt;
  assign rise     = s2 & ~s3;
  assign sat      = &edge_cnt;
  assign edge_nxt = edge_cnt + CNT_W'(rise & ~sat);
  assign ovf_nxt  = ovf_i | (rise & sat);
  // the last window cycle latches the next-state count so its own edge is included
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state    <= IDLE;
      {s1, s2, s3} <= '0;
      edge_cnt <= '0;
      gate_cnt <= '0;
      ovf_i    <= 1'b0;
      DOUT     <= '0;
      VALID    <= 1'b0;
      OVF      <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      s1    <= PIN;
      s2    <= s1;
      s3    <= s2;
      VALID <= 1'b0;
      case (state)
        GATE:
          if (!EN) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= edge_nxt;
            ovf_i    <= ovf_nxt;
            if (gate_cnt == GATE_W'(GATE_CYCLES - 1)) begin
              state <= LATCH;
              BUSY  <= 1'b0;
              DOUT  <= edge_nxt;
              OVF   <= ovf_nxt;
              VALID <= 1'b1;
            end
          end
        default: begin
          state    <= EN ? GATE : IDLE;
          BUSY     <= EN;
          edge_cnt <= '0;
          gate_cnt <= '0;
          ovf_i    <= 1'b0;
        end
      endcase
    end
endmodule
